// File: rtl/vmsu_rr_arbiter.sv
// Shares one 8x8 signed/unsigned multiplier among four requesters through a two-stage pipeline.
// Define VMSU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.

module vmsu_mul8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        is_signed,
  output logic [15:0] p
);
  logic [15:0] a_ext;
  logic [15:0] b_ext;

  // The low 16 bits of the sign-extended product are the exact two's complement result.
  assign a_ext = {{8{is_signed & a[7]}}, a};
  assign b_ext = {{8{is_signed & b[7]}}, b};
  assign p     = a_ext * b_ext;
endmodule

module vmsu_rr_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_p,
  output logic [1:0]  rsp_id,
  output logic [1:0]  inflight
);
  logic [7:0]  op_a [4];
  logic [7:0]  op_b [4];

  logic        s1_valid_reg;
  logic [7:0]  s1_a_reg;
  logic [7:0]  s1_b_reg;
  logic        s1_signed_reg;
  logic [1:0]  s1_id_reg;
  logic        s2_valid_reg;
  logic [15:0] s2_p_reg;
  logic [1:0]  s2_id_reg;
  logic [1:0]  inflight_reg;

  logic        advance1;
  logic        advance2;
  logic [1:0]  winner;
  logic        any_req;
  logic        hs;
  logic        deliver;
  logic [15:0] product;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_req
      assign op_a[gi]      = req_a[8*gi +: 8];
      assign op_b[gi]      = req_b[8*gi +: 8];
      assign req_ready[gi] = rst & any_req & advance1 & (winner == 2'(gi));
    end
  endgenerate

  assign advance2 = !s2_valid_reg | rsp_ready;
  assign advance1 = !s1_valid_reg | advance2;
  assign hs       = rst & any_req & advance1;
  assign deliver  = s2_valid_reg & rsp_ready;

`ifdef VMSU_ARB_FIXED_PRIO_EN
  always_comb begin
    winner  = 2'd0;
    any_req = 1'b0;
    // Descending scan so the lowest index found last wins.
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i]) begin
        winner  = 2'(i);
        any_req = 1'b1;
      end
    end
  end
`else
  logic [1:0] ptr_reg;

  always_comb begin
    winner  = ptr_reg;
    any_req = 1'b0;
    // Descending offset scan so the requester closest to ptr wins.
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[ptr_reg + 2'(i)]) begin
        winner  = ptr_reg + 2'(i);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= 2'd0;
    end else if (hs) begin
      ptr_reg <= winner + 2'd1;
    end
  end
`endif

  vmsu_mul8x8 u_mul (
    .a         (s1_a_reg),
    .b         (s1_b_reg),
    .is_signed (s1_signed_reg),
    .p         (product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= 8'd0;
      s1_b_reg      <= 8'd0;
      s1_signed_reg <= 1'b0;
      s1_id_reg     <= 2'd0;
      s2_valid_reg  <= 1'b0;
      s2_p_reg      <= 16'd0;
      s2_id_reg     <= 2'd0;
    end else begin
      if (advance1) begin
        s1_valid_reg <= hs;
        if (hs) begin
          s1_a_reg      <= op_a[winner];
          s1_b_reg      <= op_b[winner];
          s1_signed_reg <= req_ctrl[winner];
          s1_id_reg     <= winner;
        end
      end
      if (advance2) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_p_reg  <= product;
          s2_id_reg <= s1_id_reg;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_reg <= 2'd0;
    end else begin
      case ({hs, deliver})
        2'b10:   inflight_reg <= inflight_reg + 2'd1;
        2'b01:   inflight_reg <= inflight_reg - 2'd1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  assign rsp_valid = s2_valid_reg;
  assign rsp_p     = s2_p_reg;
  assign rsp_id    = s2_id_reg;
  assign inflight  = inflight_reg;
endmodule
